i2c_slave_data_out: RTL

I2C slave transmit engine for read transactions: after the slave controller has ACKed a read address, it serialises up to NUM_BYTES preloaded bytes onto SDA MSB-first and samples the master's ACK/NACK after each byte. It is the counterpart of the slave "data in" path and shares its inputs: oversampled SCL/SDA from the FPGA clock domain (current plus previous sample) and an open-drain SDA pull-down request. It sits beside the receive path under the slave top level, which arbitrates `SDA_down` between the two.

---
 rtl/i2c_slave_data_out.sv | 238 +++++++++++++++++++++++
 1 files changed

// File: rtl/i2c_slave_data_out.sv
// -----------------------------------------------------------------------------
// i2c_slave_data_out
//
// I2C slave transmit engine for read transactions. Once the slave controller
// has ACKed a read address (SCL low after the address-ACK falling edge) it
// pulses `enable`. The block then latches up to NUM_BYTES bytes, shifts them
// onto SDA MSB-first through an open-drain pull-down request, and samples
// the master's ACK/NACK after every byte. A master NACK, or the last byte
// being acknowledged, ends the transfer with a one-cycle `done`. A START or
// STOP seen mid-transfer ends it with a one-cycle `abort`.
//
// SCL/SDA arrive already synchronised to FPGA_clk, together with their
// previous-cycle samples, so all edge and bus-condition detection happens here.
//
// Ports
//   FPGA_clk    in   system clock
//   rst_n       in   asynchronous active-low reset
//   SCL         in   current synchronised SCL sample
//   SCL_prev    in   SCL sample from the previous FPGA_clk
//   SDA         in   current synchronised SDA sample
//   SDA_prev    in   SDA sample from the previous FPGA_clk
//   enable      in   start pulse; honoured only while idle
//   tx_data     in   NUM_BYTES bytes, element 0 sent first; latched on start
//   SDA_down    out  1 = pull SDA low, 0 = release
//   busy        out  high in every state except idle
//   done        out  one-cycle pulse at the normal end of a transfer
//   nack        out  master NACKed the last byte; held until the next start
//   abort       out  one-cycle pulse on START/STOP mid-transfer
//   bytes_sent  out  bytes completed (ACKed or NACKed) in this transfer
// -----------------------------------------------------------------------------
module i2c_slave_data_out #(
    parameter int NUM_BYTES = 6
) (
    input  logic                          FPGA_clk,
    input  logic                          rst_n,
    input  logic                          SCL,
    input  logic                          SCL_prev,
    input  logic                          SDA,
    input  logic                          SDA_prev,
    input  logic                          enable,
    input  logic [NUM_BYTES-1:0][7:0]     tx_data,
    output logic                          SDA_down,
    output logic                          busy,
    output logic                          done,
    output logic                          nack,
    output logic                          abort,
    output logic [$clog2(NUM_BYTES):0]    bytes_sent
);

    localparam int IDX_W = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
    localparam int CNT_W = $clog2(NUM_BYTES) + 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BYTES - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEND,
        ST_ACK_WAIT,
        ST_ACK_END,
        ST_DONE
    } state_t;

    // ---------------------------------------------------------------------
    // Registers
    // ---------------------------------------------------------------------
    state_t                      r_state;
    logic [NUM_BYTES-1:0][7:0]   r_shadow;
    logic [2:0]                  r_bit_idx;
    logic [IDX_W-1:0]            r_byte_idx;
    logic [CNT_W-1:0]            r_bytes_sent;
    logic                        r_sda_down;
    logic                        r_busy;
    logic                        r_done;
    logic                        r_nack;
    logic                        r_abort;

    // ---------------------------------------------------------------------
    // Next-state values
    // ---------------------------------------------------------------------
    state_t                      w_state_nxt;
    logic [2:0]                  w_bit_idx_nxt;
    logic [IDX_W-1:0]            w_byte_idx_nxt;
    logic [CNT_W-1:0]            w_bytes_sent_nxt;
    logic                        w_sda_down_nxt;
    logic                        w_done_nxt;
    logic                        w_nack_nxt;
    logic                        w_abort_nxt;
    logic                        w_latch;

    // Bus event decode. bus_cond needs SCL high in both samples, so it can
    // never coincide with a falling edge.
    logic                        w_fall;
    logic                        w_rise;
    logic                        w_bus_cond;
    logic [IDX_W-1:0]            w_byte_inc;

    assign w_fall     = SCL_prev & ~SCL;
    assign w_rise     = ~SCL_prev & SCL;
    assign w_bus_cond = SCL & SCL_prev & (SDA != SDA_prev);
    assign w_byte_inc = r_byte_idx + IDX_W'(1);

    // ---------------------------------------------------------------------
    // Next-state / output logic
    // ---------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path
        // leaves one unassigned and no latch is inferred.
        w_state_nxt      = r_state;
        w_bit_idx_nxt    = r_bit_idx;
        w_byte_idx_nxt   = r_byte_idx;
        w_bytes_sent_nxt = r_bytes_sent;
        w_sda_down_nxt   = r_sda_down;
        w_nack_nxt       = r_nack;
        w_done_nxt       = 1'b0;
        w_abort_nxt      = 1'b0;
        w_latch          = 1'b0;

        unique case (r_state)
            ST_IDLE: begin
                if (enable) begin
                    // SCL is already low here, so the MSB can go out at once.
                    w_latch          = 1'b1;
                    w_byte_idx_nxt   = '0;
                    w_bit_idx_nxt    = 3'd7;
                    w_bytes_sent_nxt = '0;
                    w_nack_nxt       = 1'b0;
                    w_sda_down_nxt   = ~tx_data[0][7];
                    w_state_nxt      = ST_SEND;
                end
            end

            ST_SEND: begin
                if (w_bus_cond) begin
                    w_sda_down_nxt = 1'b0;
                    w_abort_nxt    = 1'b1;
                    w_state_nxt    = ST_IDLE;
                end else if (w_fall) begin
                    if (r_bit_idx == 3'd0) begin
                        // Release SDA for the master's ACK/NACK slot.
                        w_sda_down_nxt = 1'b0;
                        w_state_nxt    = ST_ACK_WAIT;
                    end else begin
                        w_bit_idx_nxt  = r_bit_idx - 3'd1;
                        w_sda_down_nxt = ~r_shadow[r_byte_idx][r_bit_idx - 3'd1];
                    end
                end
            end

            ST_ACK_WAIT: begin
                if (w_bus_cond) begin
                    w_sda_down_nxt = 1'b0;
                    w_abort_nxt    = 1'b1;
                    w_state_nxt    = ST_IDLE;
                end else if (w_rise) begin
                    // Released bus reads high, so a high sample is a NACK.
                    w_nack_nxt       = SDA;
                    w_bytes_sent_nxt = r_bytes_sent + CNT_W'(1);
                    w_state_nxt      = ST_ACK_END;
                end
            end

            ST_ACK_END: begin
                if (w_bus_cond) begin
                    w_sda_down_nxt = 1'b0;
                    w_abort_nxt    = 1'b1;
                    w_state_nxt    = ST_IDLE;
                end else if (w_fall) begin
                    if (r_nack || (r_byte_idx == LAST_IDX)) begin
                        w_sda_down_nxt = 1'b0;
                        w_state_nxt    = ST_DONE;
                    end else begin
                        w_byte_idx_nxt = w_byte_inc;
                        w_bit_idx_nxt  = 3'd7;
                        w_sda_down_nxt = ~r_shadow[w_byte_inc][7];
                        w_state_nxt    = ST_SEND;
                    end
                end
            end

            ST_DONE: begin
                w_sda_down_nxt = 1'b0;
                w_done_nxt     = 1'b1;
                w_state_nxt    = ST_IDLE;
            end

            default: begin
                w_sda_down_nxt = 1'b0;
                w_state_nxt    = ST_IDLE;
            end
        endcase
    end

    // ---------------------------------------------------------------------
    // State and output registers
    // ---------------------------------------------------------------------
    // busy is registered from the next state so it falls on the same edge
    // that done/abort rise.
    always_ff @(posedge FPGA_clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values, independent of block order.
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_bit_idx    <= '0;
            r_byte_idx   <= '0;
            r_bytes_sent <= '0;
            r_sda_down   <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_nack       <= 1'b0;
            r_abort      <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_bit_idx    <= w_bit_idx_nxt;
            r_byte_idx   <= w_byte_idx_nxt;
            r_bytes_sent <= w_bytes_sent_nxt;
            r_sda_down   <= w_sda_down_nxt;
            r_busy       <= (w_state_nxt != ST_IDLE);
            r_done       <= w_done_nxt;
            r_nack       <= w_nack_nxt;
            r_abort      <= w_abort_nxt;
        end
    end

    // NOTE: the shadow bytes carry no reset; they are only read after a
    // start has loaded them, so a reset would only add a load on rst_n.
    always_ff @(posedge FPGA_clk) begin
        if (w_latch) begin
            r_shadow <= tx_data;
        end
    end

    assign SDA_down   = r_sda_down;
    assign busy       = r_busy;
    assign done       = r_done;
    assign nack       = r_nack;
    assign abort      = r_abort;
    assign bytes_sent = r_bytes_sent;

endmodule
